// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and forwarding controller for a 4-stage (IF, ID, EX, WB) pipeline.
//   Keeps shadow copies of the EX and WB stage write info. Each cycle it decides
//   whether to stall ID and insert an EX bubble, and registers the forwarding
//   selects for the instruction that is entering EX.
//
// Ports
//   i_clk, i_rst             clock (rising edge), async active-high reset
//   i_id_valid               ID stage holds a real instruction
//   i_id_rs1, i_id_rs2       ID source registers (rs2 only meaningful with i_id_use2)
//   i_id_rd, i_id_regwrite   ID destination / writes register file
//   i_id_writesrc            1 = late result (ready end of WB), 0 = ALU (ready end of EX)
//   i_flush                  branch taken in EX, squash the ID instruction
//   o_stall                  hold PC and IF/ID
//   o_bubble                 ID/EX loads zeros this edge
//   o_fwd_sel1, o_fwd_sel2   EX operand source: 00 regfile, 01 WB result, 10 WB bypass latch
//   o_ex_rd, o_ex_regwrite, o_ex_writesrc   EX shadow (debug)
//   o_stall_cnt, o_fwd_cnt   saturating statistic counters
module pipe_hazard_ctrl #(
  parameter int REGW = 3,
  parameter int CNTW = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_id_valid,
  input  logic [REGW-1:0] i_id_rs1,
  input  logic [REGW-1:0] i_id_rs2,
  input  logic            i_id_use2,
  input  logic [REGW-1:0] i_id_rd,
  input  logic            i_id_regwrite,
  input  logic            i_id_writesrc,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_bubble,
  output logic [1:0]      o_fwd_sel1,
  output logic [1:0]      o_fwd_sel2,
  output logic [REGW-1:0] o_ex_rd,
  output logic            o_ex_regwrite,
  output logic            o_ex_writesrc,
  output logic [CNTW-1:0] o_stall_cnt,
  output logic [CNTW-1:0] o_fwd_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_BYP = 2'b10;

  logic            r_ex_valid;
  logic [REGW-1:0] r_ex_rd;
  logic            r_ex_regwrite;
  logic            r_ex_writesrc;
  logic            r_wb_valid;
  logic [REGW-1:0] r_wb_rd;
  logic            r_wb_regwrite;
  logic [1:0]      r_fwd_sel1;
  logic [1:0]      r_fwd_sel2;
  logic [CNTW-1:0] r_stall_cnt;
  logic [CNTW-1:0] r_fwd_cnt;

  logic       w_hit_ex1;
  logic       w_hit_ex2;
  logic       w_hit_wb1;
  logic       w_hit_wb2;
  logic       w_stall;
  logic       w_bubble;
  logic [1:0] w_sel1;
  logic [1:0] w_sel2;

  assign w_hit_ex1 = r_ex_valid & r_ex_regwrite & (r_ex_rd == i_id_rs1);
  assign w_hit_ex2 = i_id_use2 & r_ex_valid & r_ex_regwrite & (r_ex_rd == i_id_rs2);
  assign w_hit_wb1 = r_wb_valid & r_wb_regwrite & (r_wb_rd == i_id_rs1);
  assign w_hit_wb2 = i_id_use2 & r_wb_valid & r_wb_regwrite & (r_wb_rd == i_id_rs2);

  // A late producer in EX can only be consumed from the WB bypass, one cycle
  // later. After the stall the producer sits in WB, so the stall self-clears.
  assign w_stall  = i_id_valid & ~i_flush & ~i_rst & r_ex_writesrc & (w_hit_ex1 | w_hit_ex2);
  assign w_bubble = w_stall | i_flush | ~i_id_valid | i_rst;

  // EX hit wins over WB hit: the newer producer holds the architectural value.
  // An EX hit that survives to here is always an ALU producer, since a late
  // EX hit forces a bubble.
  always_comb begin
    w_sel1 = SEL_RF;
    w_sel2 = SEL_RF;
    if (!w_bubble) begin
      if (w_hit_ex1)      w_sel1 = SEL_WB;
      else if (w_hit_wb1) w_sel1 = SEL_BYP;
      if (w_hit_ex2)      w_sel2 = SEL_WB;
      else if (w_hit_wb2) w_sel2 = SEL_BYP;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_rd       <= '0;
      r_ex_regwrite <= 1'b0;
      r_ex_writesrc <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_wb_rd       <= '0;
      r_wb_regwrite <= 1'b0;
      r_fwd_sel1    <= SEL_RF;
      r_fwd_sel2    <= SEL_RF;
      r_stall_cnt   <= '0;
      r_fwd_cnt     <= '0;
    end else begin
      r_wb_valid    <= r_ex_valid;
      r_wb_rd       <= r_ex_rd;
      r_wb_regwrite <= r_ex_regwrite;
      if (!w_bubble) begin
        r_ex_valid    <= 1'b1;
        r_ex_rd       <= i_id_rd;
        r_ex_regwrite <= i_id_regwrite;
        r_ex_writesrc <= i_id_writesrc;
      end else begin
        r_ex_valid    <= 1'b0;
        r_ex_rd       <= '0;
        r_ex_regwrite <= 1'b0;
        r_ex_writesrc <= 1'b0;
      end
      r_fwd_sel1 <= w_sel1;
      r_fwd_sel2 <= w_sel2;
      if (w_stall && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + CNTW'(1);
      if (((w_sel1 | w_sel2) != SEL_RF) && !(&r_fwd_cnt))
        r_fwd_cnt <= r_fwd_cnt + CNTW'(1);
    end
  end

  assign o_stall       = w_stall;
  assign o_bubble      = w_bubble;
  assign o_fwd_sel1    = r_fwd_sel1;
  assign o_fwd_sel2    = r_fwd_sel2;
  assign o_ex_rd       = r_ex_rd;
  assign o_ex_regwrite = r_ex_regwrite;
  assign o_ex_writesrc = r_ex_writesrc;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_fwd_cnt     = r_fwd_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and forwarding controller for the 4-stage pipeline (IF, ID, EX, WB) with 8-bit data and 8 registers (3-bit addresses).
- Sits beside the ID/EX pipeline register and keeps shadow copies of the EX and WB stage write info (dest reg, regwrite, writesrc).
- Decides three things each cycle: stall ID and insert an EX bubble, flush the ID instruction, and select the forwarding source for each EX operand.
- Keeps saturating stall and forward counters for debug.

Parameters:
- REGW, 3, register address width.
- CNTW, 8, width of the statistic counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs1  in  REGW  ID source register 1.
- id_rs2  in  REGW  ID source register 2.
- id_use2  in  1  the ID instruction reads rs2.
- id_rd  in  REGW  ID destination register.
- id_regwrite  in  1  the ID instruction writes the register file.
- id_writesrc  in  1  1 = late result (memory/slow source), ready only at the end of WB; 0 = ALU result, ready at the end of EX.
- flush  in  1  branch taken in EX; squash the ID instruction.
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- bubble  out  1  ID/EX must load zeros (regwrite=0) this edge.
- fwd_sel1  out  2  EX operand 1 source: 00 = regfile, 01 = WB-stage result, 10 = write-back bypass latch.
- fwd_sel2  out  2  EX operand 2 source, same encoding.
- ex_rd, ex_regwrite, ex_writesrc  out  REGW/1/1  EX shadow (debug).
- stall_cnt  out  CNTW  saturating count of stall cycles.
- fwd_cnt  out  CNTW  saturating count of cycles with any fwd_sel != 00.

Behaviour:
- Reset (async, rst=1): all shadow registers, fwd_sel1/2, stall_cnt and fwd_cnt go to 0 immediately. While rst=1, stall=0 and bubble=1.
- Shadow pipeline, updated on each clk edge:
  - The WB shadow takes the EX shadow.
  - The EX shadow takes the ID fields when the ID instruction advances (id_valid=1, stall=0, flush=0).
  - Otherwise the EX shadow loads {valid=0, regwrite=0}.
- Combinational hazard terms, evaluated on the current cycle's inputs:
  - hit_ex(rs) = ex_valid & ex_regwrite & (ex_rd == rs).
  - hit_wb(rs) = wb_valid & wb_regwrite & (wb_rd == rs).
  - rs2 terms are qualified by id_use2.
- stall = id_valid & ~flush & ~rst & ex_writesrc & (hit_ex(rs1) | hit_ex(rs2)).
  - This is a load-use case and costs exactly one cycle: next cycle the producer is in the WB shadow and the hit is no longer in EX.
- bubble = stall | flush | ~id_valid | rst.
- fwd_sel, registered on the same edge the consumer enters EX, so it is aligned with the ID/EX outputs:
  - Per operand, priority EX hit over WB hit (the newest value wins).
  - hit_ex with ex_writesrc=0 → 01.
  - hit_wb → 10. This applies both to ALU producers two ahead and to the late producer after a stall.
  - Otherwise → 00.
  - A bubble edge loads 00.
  - Rules for rs2 apply only when id_use2=1; else fwd_sel2 is 00.
- All 8 registers are ordinary; register 0 is forwarded like any other.
- Counters:
  - stall_cnt increments on each edge where stall=1.
  - fwd_cnt increments on each edge that loads a nonzero fwd_sel.
  - Both saturate at all-ones and never wrap.
- Simultaneous events:
  - flush overrides stall: stall=0, the ID instruction is killed, and the EX shadow takes a bubble.
  - A late hit on both rs1 and rs2 stalls only one cycle.
  - If rst asserts mid-stall, the next cycle after rst deasserts starts with empty shadows and no stall.

Test Plan:
- Reset: drive rst=1 asynchronously mid-cycle → every output is 0 before the next edge (bubble=1); counters read 0 after release.
- ALU back-to-back: I1 (rd=3, regwrite=1, writesrc=0), then I2 (rs1=3) → stall never asserts; fwd_sel1=01 when I2 is in EX; fwd_cnt=1.
- Load-use: I1 (rd=5, writesrc=1), then I2 (rs2=5, use2=1) → stall=1 for exactly one cycle; bubble enters EX; then fwd_sel2=10 when I2 is in EX; stall_cnt=1.
- Priority: I1 (rd=2), I2 (rd=2), I3 (rs1=2), all ALU → fwd_sel1=01 (from I2), not 10.
- Flush during stall: load-use condition plus flush=1 in the same cycle → stall=0, bubble=1; the EX shadow is invalid next cycle; stall_cnt unchanged.
- Saturation: hold load-use stalls for 300 cycles → stall_cnt holds at 255.
